// File: rtl/master_top.sv
// Master board controller for a two-player Battleship game.
// Player A plays on this board; player B's ship checks happen on a
// slave board and arrive here as LivB/OKB, with B's attack map on B.
// The block runs the turn FSM, strobes load requests to the slave and
// drives a 4-digit multiplexed common-anode 7-segment display.

module master_top #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        BTN1A,
  input  logic        BTN1B,
  input  logic        BTN2A,
  input  logic        BTN2B,
  input  logic        BTN3A,
  input  logic        BTN3B,
  input  logic        LivB,
  input  logic        OKB,
  output logic        LDR1B,
  output logic        LDR2B,
  output logic [15:0] A_Attack,
  output logic [2:0]  DispB,
  output logic        ST,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  // Game states; the encoding doubles as the code shown on the slave display.
  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_A_LD  = 3'd1;
  localparam logic [2:0] S_A_ATK = 3'd2;
  localparam logic [2:0] S_B_LD  = 3'd3;
  localparam logic [2:0] S_B_ATK = 3'd4;
  localparam logic [2:0] S_A_WIN = 3'd5;
  localparam logic [2:0] S_B_WIN = 3'd6;

  // Glyph codes for the display decoder: 0..9 are decimal digits.
  localparam logic [3:0] G_A     = 4'd10;
  localparam logic [3:0] G_B     = 4'd11;
  localparam logic [3:0] G_DASH  = 4'd12;
  localparam logic [3:0] G_BLANK = 4'd13;

  logic [2:0]              r_state;
  logic [2:0]              w_nextState;
  logic [15:0]             r_shipA;
  logic [15:0]             r_prevA;
  logic [15:0]             r_prevB;
  logic [15:0]             r_aAttack;
  logic                    r_rdyA;
  logic                    r_rdyB;
  logic                    r_ldr1b;
  logic                    r_ldr2b;
  logic [REFRESH_BITS-1:0] r_refresh;

  logic        w_newGame;
  logic        w_clearAll;
  logic [15:0] w_aDelta;
  logic        w_oka;
  logic [15:0] w_hitMap;
  logic [4:0]  w_hitCount;
  logic        w_tensDigit;
  logic [3:0]  w_onesDigit;
  logic [1:0]  w_digitSel;
  logic [3:0]  w_letterCode;
  logic [3:0]  w_glyphCode;
  logic [3:0]  w_anode;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a glyph code.
  function automatic logic [6:0] segmentPattern(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      G_A:     pat = 7'h77;
      G_B:     pat = 7'h7C;
      G_DASH:  pat = 7'h40;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  // New game (both players pressing BTN3) behaves exactly like reset.
  assign w_newGame  = BTN3A & BTN3B;
  assign w_clearAll = ~clr | w_newGame;

  // A's attack is legal when it keeps every earlier shot and adds exactly one.
  assign w_aDelta = A ^ r_prevA;
  assign w_oka    = ((A & r_prevA) == r_prevA) &&
                    (w_aDelta != 16'd0) &&
                    ((w_aDelta & (w_aDelta - 16'd1)) == 16'd0);

  // Turn sequencing: who moves next and when the game is decided.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_LOAD: begin
        if (r_rdyA && r_rdyB) w_nextState = S_A_LD;
      end
      S_A_LD: begin
        if (!LivB)                 w_nextState = S_A_WIN;
        else if (BTN2A && w_oka)   w_nextState = S_A_ATK;
      end
      S_A_ATK: begin
        w_nextState = S_B_LD;
      end
      S_B_LD: begin
        if (!LivB)                 w_nextState = S_A_WIN;
        else if (BTN2B && OKB)     w_nextState = S_B_ATK;
      end
      S_B_ATK: begin
        if ((r_shipA & ~B) == 16'd0) w_nextState = S_B_WIN;
        else                         w_nextState = S_A_LD;
      end
      S_A_WIN, S_B_WIN: begin
        w_nextState = r_state;
      end
      default: begin
        w_nextState = S_LOAD;
      end
    endcase
  end

  // State register; reset and new game both return to ship loading.
  always_ff @(posedge clk) begin
    if (w_clearAll) r_state <= S_LOAD;
    else            r_state <= w_nextState;
  end

  // Ship loading: A's layout is captured from the switches, both players flag readiness.
  always_ff @(posedge clk) begin
    if (w_clearAll) begin
      r_shipA <= 16'd0;
      r_rdyA  <= 1'b0;
      r_rdyB  <= 1'b0;
    end else if (r_state == S_LOAD) begin
      if (BTN1A) begin
        r_shipA <= A;
        r_rdyA  <= 1'b1;
      end
      if (BTN1B) r_rdyB <= 1'b1;
    end
  end

  // Load strobes to the slave: B's ship load on its first confirm, A's attack after commit.
  always_ff @(posedge clk) begin
    if (w_clearAll) begin
      r_ldr1b <= 1'b0;
      r_ldr2b <= 1'b0;
    end else begin
      r_ldr1b <= (r_state == S_LOAD) && BTN1B && !r_rdyB;
      r_ldr2b <= (r_state == S_A_ATK);
    end
  end

  // Attack history: A's committed map and the last map B fired with.
  always_ff @(posedge clk) begin
    if (w_clearAll) begin
      r_aAttack <= 16'd0;
      r_prevA   <= 16'd0;
      r_prevB   <= 16'd0;
    end else begin
      if (r_state == S_A_ATK) begin
        r_aAttack <= A;
        r_prevA   <= A;
      end
      if (r_state == S_B_ATK) r_prevB <= B;
    end
  end

  // Free-running refresh counter whose top two bits pick the lit digit.
  always_ff @(posedge clk) begin
    if (w_clearAll) r_refresh <= '0;
    else            r_refresh <= r_refresh + 1'b1;
  end

  // Number of A's ship cells that B has hit so far.
  assign w_hitMap = r_shipA & r_prevB;

  always_comb begin
    w_hitCount = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_hitCount = w_hitCount + {4'd0, w_hitMap[i]};
    end
  end

  // Split the 0..16 hit count into tens and ones; 4-bit wrap keeps 16 -> 6 correct.
  assign w_tensDigit = (w_hitCount >= 5'd10);
  assign w_onesDigit = w_hitCount[3:0] - (w_tensDigit ? 4'd10 : 4'd0);

  // Leftmost digit tells whose turn it is (or that ships are being loaded).
  always_comb begin
    w_letterCode = G_B;
    case (r_state)
      S_LOAD:                    w_letterCode = G_DASH;
      S_A_LD, S_A_ATK, S_A_WIN:  w_letterCode = G_A;
      default:                   w_letterCode = G_B;
    endcase
  end

  assign w_digitSel = r_refresh[REFRESH_BITS-1:REFRESH_BITS-2];

  // Digit multiplexer: one anode low at a time, glyph chosen for that position.
  always_comb begin
    w_anode     = 4'b1110;
    w_glyphCode = w_onesDigit;
    case (w_digitSel)
      2'd0: begin
        w_anode     = 4'b1110;
        w_glyphCode = w_onesDigit;
      end
      2'd1: begin
        w_anode     = 4'b1101;
        w_glyphCode = {3'b000, w_tensDigit};
      end
      2'd2: begin
        w_anode     = 4'b1011;
        w_glyphCode = G_BLANK;
      end
      default: begin
        w_anode     = 4'b0111;
        w_glyphCode = w_letterCode;
      end
    endcase
  end

  assign an       = w_anode;
  assign seg      = {1'b1, ~segmentPattern(w_glyphCode)};
  assign LDR1B    = r_ldr1b;
  assign LDR2B    = r_ldr2b;
  assign A_Attack = r_aAttack;
  assign DispB    = r_state;
  assign ST       = (r_state == S_A_LD) || (r_state == S_A_ATK);

endmodule

// File: tb/tb_master_top.sv
// Self-checking bench for master_top: directed game scenarios followed by
// randomized play, all outputs compared every cycle against a game model.

module tb_master_top;

  localparam int RB = 4;

  // Game phases by their display code.
  localparam int M_LOAD  = 0;
  localparam int M_A_LD  = 1;
  localparam int M_A_ATK = 2;
  localparam int M_B_LD  = 3;
  localparam int M_B_ATK = 4;
  localparam int M_A_WIN = 5;
  localparam int M_B_WIN = 6;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] A;
  logic [15:0] B;
  logic        BTN1A, BTN1B, BTN2A, BTN2B, BTN3A, BTN3B;
  logic        LivB, OKB;
  logic        LDR1B, LDR2B;
  logic [15:0] A_Attack;
  logic [2:0]  DispB;
  logic        ST;
  logic [7:0]  seg;
  logic [3:0]  an;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model of the game.
  int          mSt;
  logic [15:0] mShipA, mPrevA, mPrevB, mAtt;
  bit          mRdyA, mRdyB, mLdr1, mLdr2;
  int          mCnt;

  master_top #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .clr(clr), .A(A), .B(B),
    .BTN1A(BTN1A), .BTN1B(BTN1B), .BTN2A(BTN2A), .BTN2B(BTN2B),
    .BTN3A(BTN3A), .BTN3B(BTN3B), .LivB(LivB), .OKB(OKB),
    .LDR1B(LDR1B), .LDR2B(LDR2B), .A_Attack(A_Attack), .DispB(DispB),
    .ST(ST), .seg(seg), .an(an)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // A move is legal if all earlier shots remain and exactly one new cell is added.
  function automatic bit legalA(input logic [15:0] a, input logic [15:0] p);
    return ((a & p) == p) && ($countones(a ^ p) == 1);
  endfunction

  // Active-low 7-segment codes with DP off: 0..9, 10='A', 11='b', 12='-', 13=blank.
  function automatic logic [7:0] glyph(input int ch);
    logic [7:0] t [14];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hBF, 8'hFF};
    return t[ch];
  endfunction

  // Advance the model by one clock, using the inputs present before the edge.
  task automatic modelStep();
    bit wasReady;
    if (!clr || (BTN3A && BTN3B)) begin
      mSt = M_LOAD; mShipA = 0; mPrevA = 0; mPrevB = 0; mAtt = 0;
      mRdyA = 0; mRdyB = 0; mLdr1 = 0; mLdr2 = 0; mCnt = 0;
      return;
    end
    mCnt  = (mCnt + 1) % (1 << RB);
    mLdr1 = 0;
    mLdr2 = 0;
    case (mSt)
      M_LOAD: begin
        wasReady = mRdyA && mRdyB;
        if (BTN1B && !mRdyB) mLdr1 = 1;
        if (BTN1A) begin mShipA = A; mRdyA = 1; end
        if (BTN1B) mRdyB = 1;
        if (wasReady) mSt = M_A_LD;
      end
      M_A_LD: begin
        if (!LivB) mSt = M_A_WIN;
        else if (BTN2A && legalA(A, mPrevA)) mSt = M_A_ATK;
      end
      M_A_ATK: begin
        mAtt = A; mPrevA = A; mLdr2 = 1; mSt = M_B_LD;
      end
      M_B_LD: begin
        if (!LivB) mSt = M_A_WIN;
        else if (BTN2B && OKB) mSt = M_B_ATK;
      end
      M_B_ATK: begin
        mPrevB = B;
        mSt = ((mShipA & ~B) == 16'd0) ? M_B_WIN : M_A_LD;
      end
      default: ;
    endcase
  endtask

  // Compare every output against the model.
  task automatic checkCycle();
    int digit, hits, ch;
    digit = (mCnt >> (RB - 2)) & 3;
    hits  = $countones(mShipA & mPrevB);
    case (digit)
      0:       ch = hits % 10;
      1:       ch = hits / 10;
      2:       ch = 13;
      default: ch = (mSt == M_LOAD) ? 12 :
                    (mSt == M_A_LD || mSt == M_A_ATK || mSt == M_A_WIN) ? 10 : 11;
    endcase
    checkOutput("DispB", {29'd0, DispB}, mSt);
    checkOutput("ST", {31'd0, ST}, {31'd0, (mSt == M_A_LD || mSt == M_A_ATK)});
    checkOutput("LDR1B", {31'd0, LDR1B}, {31'd0, mLdr1});
    checkOutput("LDR2B", {31'd0, LDR2B}, {31'd0, mLdr2});
    checkOutput("A_Attack", {16'd0, A_Attack}, {16'd0, mAtt});
    checkOutput("an", {28'd0, an}, {28'd0, 4'hF ^ (4'd1 << digit)});
    checkOutput("seg", {24'd0, seg}, {24'd0, glyph(ch)});
  endtask

  // One clock of stimulus: model update, edge, then sample away from the edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkCycle();
  endtask

  task automatic releaseButtons();
    BTN1A = 0; BTN1B = 0; BTN2A = 0; BTN2B = 0; BTN3A = 0; BTN3B = 0;
  endtask

  initial begin
    clr = 0; A = 0; B = 0; LivB = 1; OKB = 0;
    releaseButtons();
    @(negedge clk);
    repeat (2) applyStimulus();
    checkOutput("rst_dispb", {29'd0, DispB}, 0);
    checkOutput("rst_attack", {16'd0, A_Attack}, 0);
    checkOutput("rst_an", {28'd0, an}, 32'hE);
    checkOutput("rst_seg", {24'd0, seg}, 32'hC0);

    // Both players load ships in the same cycle.
    clr = 1; A = 16'hE606; BTN1A = 1; BTN1B = 1;
    applyStimulus();
    checkOutput("load_ldr1b", {31'd0, LDR1B}, 1);
    releaseButtons();
    applyStimulus();
    checkOutput("load_dispb", {29'd0, DispB}, 1);
    checkOutput("load_st", {31'd0, ST}, 1);

    // A fires a legal single shot.
    A = 16'h8000; BTN2A = 1;
    applyStimulus();
    checkOutput("aatk_dispb", {29'd0, DispB}, 2);
    BTN2A = 0;
    applyStimulus();
    checkOutput("aatk_bld", {29'd0, DispB}, 3);
    checkOutput("aatk_map", {16'd0, A_Attack}, 32'h8000);
    checkOutput("aatk_ldr2b", {31'd0, LDR2B}, 1);

    // B's shot waits for the slave's OK.
    B = 16'h2000; BTN2B = 1; OKB = 0;
    applyStimulus();
    checkOutput("batk_wait", {29'd0, DispB}, 3);
    OKB = 1;
    applyStimulus();
    checkOutput("batk_dispb", {29'd0, DispB}, 4);
    BTN2B = 0; OKB = 0;
    applyStimulus();
    checkOutput("batk_back", {29'd0, DispB}, 1);

    // Illegal A shots are ignored, then a legal one goes through.
    A = 16'h8000; BTN2A = 1;
    applyStimulus();
    checkOutput("illegal_same", {29'd0, DispB}, 1);
    A = 16'hC001;
    applyStimulus();
    checkOutput("illegal_two", {29'd0, DispB}, 1);
    checkOutput("illegal_ldr2b", {31'd0, LDR2B}, 0);
    A = 16'hC000;
    applyStimulus();
    BTN2A = 0;
    applyStimulus();
    checkOutput("legal_map", {16'd0, A_Attack}, 32'hC000);

    // B covers every ship cell and wins.
    B = 16'hE606; BTN2B = 1; OKB = 1;
    applyStimulus();
    BTN2B = 0; OKB = 0;
    applyStimulus();
    checkOutput("bwin_dispb", {29'd0, DispB}, 6);
    repeat (16) applyStimulus();

    // New game, replay to B_LD, then B has no ships left.
    BTN3A = 1; BTN3B = 1;
    applyStimulus();
    checkOutput("ng1_dispb", {29'd0, DispB}, 0);
    releaseButtons();
    A = 16'h0F0F; BTN1A = 1; BTN1B = 1;
    applyStimulus();
    releaseButtons();
    applyStimulus();
    A = 16'h0001; BTN2A = 1;
    applyStimulus();
    BTN2A = 0;
    applyStimulus();
    checkOutput("ng1_map", {16'd0, A_Attack}, 32'h0001);
    LivB = 0;
    applyStimulus();
    checkOutput("awin_bld", {29'd0, DispB}, 5);
    LivB = 1;
    applyStimulus();
    checkOutput("awin_hold", {29'd0, DispB}, 5);
    BTN3A = 1; BTN3B = 1;
    applyStimulus();
    checkOutput("ng2_dispb", {29'd0, DispB}, 0);
    checkOutput("ng2_map", {16'd0, A_Attack}, 0);
    releaseButtons();

    // LivB low while A is to move; then a mid-game reset.
    BTN1A = 1; BTN1B = 1;
    applyStimulus();
    releaseButtons();
    applyStimulus();
    LivB = 0;
    applyStimulus();
    checkOutput("awin_ald", {29'd0, DispB}, 5);
    LivB = 1;
    clr = 0;
    applyStimulus();
    checkOutput("midrst_dispb", {29'd0, DispB}, 0);
    clr = 1;

    // Randomized play.
    for (int n = 0; n < 3000; n++) begin
      bit both3;
      clr   = ($urandom_range(0, 199) != 0);
      both3 = ($urandom_range(0, 99) < 2);
      BTN3A = both3 | ($urandom_range(0, 19) == 0);
      BTN3B = both3 | ($urandom_range(0, 19) == 0);
      BTN1A = ($urandom_range(0, 3) == 0);
      BTN1B = ($urandom_range(0, 3) == 0);
      BTN2A = ($urandom_range(0, 2) == 0);
      BTN2B = ($urandom_range(0, 2) == 0);
      LivB  = ($urandom_range(0, 29) != 0);
      OKB   = ($urandom_range(0, 3) != 0);
      if (mSt == M_LOAD) A = 16'($urandom);
      else begin
        case ($urandom_range(0, 3))
          0, 1:    A = mPrevA | (16'd1 << $urandom_range(0, 15));
          2:       A = mPrevA;
          default: A = 16'($urandom);
        endcase
      end
      case ($urandom_range(0, 2))
        0:       B = mPrevB | (16'd1 << $urandom_range(0, 15));
        1:       B = mPrevB | mShipA;
        default: B = 16'($urandom);
      endcase
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/master_top.md
MASTER_TOP -- requirements
Module: master_top

Interface
REQ-001 Parameter REFRESH_BITS, default 17, SHALL set the width of the 7-segment digit-multiplex refresh counter.
REQ-002 clk  input  1  SHALL be the single rising-edge clock for all state.
REQ-003 clr  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 A  input  16  SHALL carry player A switches: ship layout in LOAD, cumulative attack map otherwise.
REQ-005 B  input  16  SHALL carry player B cumulative attack map, relayed from the slave board.
REQ-006 BTN1A, BTN1B  input  1 each  SHALL be the ship-load confirm buttons of A and B.
REQ-007 BTN2A, BTN2B  input  1 each  SHALL be the fire buttons of A and B.
REQ-008 BTN3A, BTN3B  input  1 each  SHALL be the new-game buttons.
REQ-009 LivB  input  1  SHALL be 1 while any B ship cell survives (from slave).
REQ-010 OKB  input  1  SHALL be 1 when B's pending attack is legal (from slave).
REQ-011 LDR1B, LDR2B  output  1 each  SHALL be one-cycle strobes to the slave: B-ship load, A-attack load.
REQ-012 A_Attack  output  16  SHALL hold A's last committed attack map.
REQ-013 DispB  output  3  SHALL encode the FSM state for the slave display.
REQ-014 ST  output  1  SHALL be 1 during A's turn (A_LD, A_ATK), else 0.
REQ-015 seg  output  8  and an  output  4  SHALL drive a 4-digit common-anode display, active-low, seg[7]=DP (always off).

Function
REQ-016 States/DispB codes SHALL be LOAD=0, A_LD=1, A_ATK=2, B_LD=3, B_ATK=4, A_WIN=5, B_WIN=6.
REQ-017 In any state, BTN3A&BTN3B both 1 SHALL force LOAD next cycle and clear all registers as reset does; this has priority over every other input.
REQ-018 LOAD: BTN1A SHALL latch shipA<=A and set rdyA; BTN1B SHALL set rdyB and pulse LDR1B for one cycle (only on first press); when rdyA&rdyB are both set, next state A_LD.
REQ-019 Both BTN1 pressed same cycle SHALL set both flags that cycle; transition occurs the following cycle.
REQ-020 OKA SHALL be 1 iff (A & prevA)==prevA and A^prevA has exactly one set bit.
REQ-021 A_LD: if LivB is 0 go A_WIN; else BTN2A&OKA go A_ATK; BTN2A with OKA=0 SHALL be ignored (stay).
REQ-022 A_ATK (one cycle): A_Attack<=A, prevA<=A, LDR2B=1, next B_LD.
REQ-023 B_LD: if LivB is 0 go A_WIN; else BTN2B&OKB go B_ATK; otherwise stay.
REQ-024 B_ATK (one cycle): prevB<=B; if (shipA & ~B)==0 go B_WIN else A_LD.
REQ-025 A_WIN, B_WIN SHALL hold until new game or reset.
REQ-026 Button inputs SHALL be treated as level signals sampled each clk; no debounce inside block.
REQ-027 Display: digit3 'A' in A_LD/A_ATK/A_WIN, 'b' in B_LD/B_ATK/B_WIN, '-' in LOAD; digit2 blank; digits1:0 decimal count 00-16 of popcount(shipA & prevB).
REQ-028 Digits SHALL be scanned via an (one low at a time) using counter bits [REFRESH_BITS-1:REFRESH_BITS-2].

Reset
REQ-029 clr=0 at a clk edge SHALL set state LOAD, shipA, prevA, prevB, A_Attack=0, rdyA=rdyB=0, LDR1B=LDR2B=0, refresh counter 0; mid-game reset aborts immediately.

Verification
REQ-030 Reset, then BTN1A=BTN1B=1, A=16'hE606 -> LDR1B pulse, shipA=16'hE606, state A_LD two cycles later, ST=1.
REQ-031 A_LD, A=16'h8000, BTN2A=1 -> A_ATK, A_Attack=16'h8000, LDR2B pulse, then B_LD, DispB=3.
REQ-032 A_LD, prevA=16'h8000, A=16'h8000 or 16'hC001, BTN2A=1 -> remains A_LD, no LDR2B.
REQ-033 B_LD, B=16'h2000, BTN2B=1, OKB=1 -> B_ATK then A_LD; OKB=0 -> stays B_LD.
REQ-034 B attacks cover all shipA bits -> B_WIN (DispB=6); LivB=0 in A_LD/B_LD -> A_WIN (DispB=5).
REQ-035 BTN3A=BTN3B=1 in A_WIN -> LOAD, all registers cleared, DispB=0.
